mult_div_unit: RTL and testbench

- Multi-cycle multiply/divide responder that owns the HI/LO register pair.
- The decode stage raises Start for mult/multu/div/divu/msub and HiLoWr for mthi/mtlo; this block executes the operation and returns Busy so the pipeline can stall.
- HI/LO are read combinationally by the mfhi/mflo result path.
- Sits in the execute stage beside the ALU.

---
 rtl/mult_div_unit_pkg.sv | 36 +++
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 tb/tb_mult_div_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - MDOp/HiLoWr encodings and FSM state type shared by mult_div_unit and its controller
// MDU_MADD_EN widens the set of MDOp codes that md_op_valid accepts.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MSUB  = 3'b100;
  localparam logic [2:0] MD_MADD  = 3'b101;
  localparam logic [2:0] MD_MADDU = 3'b110;
  localparam logic [2:0] MD_MSUBU = 3'b111;

  localparam logic [1:0] HILO_WR_HI = 2'b01;
  localparam logic [1:0] HILO_WR_LO = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_op_valid(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU) ||
           (op == MD_MSUB) || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUBU);
`else
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU) ||
           (op == MD_MSUB);
`endif
  endfunction

  function automatic logic md_op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle multiply/divide unit owning the HI/LO pair
// Optional madd/maddu/msubu ops are enabled by defining MDU_MADD_EN.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  HiLoWr,
  input  logic [31:0] WD,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic [2:0]     op_q, op_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;

  logic               last_cycle;
  logic               accept;
  logic [63:0]        hilo;
  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic [31:0]        a_mag, b_mag, b_sdiv, q_mag, r_mag, squo, srem;
  logic [31:0]        b_udiv, uquo, urem;
  logic [63:0]        res;
  logic               res_we;

  assign last_cycle = (state_q == ST_RUN) && (cnt_q == CW'(1));
  assign accept     = Start && md_op_valid(MDOp) && ((state_q == ST_IDLE) || last_cycle);
  assign hilo       = {hi_q, lo_q};

  assign sprod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign uprod = {32'b0, a_q} * {32'b0, b_q};

  // Signed division on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0;
  // a zero divisor is steered to 1 only to keep the datapath X-free, its result is never written.
  assign a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
  assign b_sdiv = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_sdiv;
  assign r_mag  = a_mag % b_sdiv;
  assign squo   = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
  assign srem   = a_q[31] ? (~r_mag + 32'd1) : r_mag;

  assign b_udiv = (b_q == 32'd0) ? 32'd1 : b_q;
  assign uquo   = a_q / b_udiv;
  assign urem   = a_q % b_udiv;

  always_comb begin
    res    = hilo;
    res_we = 1'b0;
    case (op_q)
      MD_MULT:  begin res = sprod;        res_we = 1'b1;              end
      MD_MULTU: begin res = uprod;        res_we = 1'b1;              end
      MD_MSUB:  begin res = hilo - sprod; res_we = 1'b1;              end
      MD_DIV:   begin res = {srem, squo}; res_we = (b_q != 32'd0);    end
      MD_DIVU:  begin res = {urem, uquo}; res_we = (b_q != 32'd0);    end
`ifdef MDU_MADD_EN
      MD_MADD:  begin res = hilo + sprod; res_we = 1'b1;              end
      MD_MADDU: begin res = hilo + uprod; res_we = 1'b1;              end
      MD_MSUBU: begin res = hilo - uprod; res_we = 1'b1;              end
`endif
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (!accept) begin
          if (HiLoWr == HILO_WR_HI) begin
            hi_d = WD;
          end else if (HiLoWr == HILO_WR_LO) begin
            lo_d = WD;
          end
        end
      end
      ST_RUN: begin
        if (last_cycle) begin
          if (res_we) begin
            {hi_d, lo_d} = res;
          end
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new op may start in IDLE or on the completing edge of the previous one.
    if (accept) begin
      state_d = ST_RUN;
      busy_d  = 1'b1;
      op_d    = MDOp;
      a_d     = A;
      b_d     = B;
      cnt_d   = md_op_is_div(MDOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized and directed bench for mult_div_unit against a cycle-count model
// Honours MDU_MADD_EN the same way as the design.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A, B, WD;
  logic [1:0]  HiLoWr;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .HiLoWr(HiLoWr), .WD(WD), .Busy(Busy), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit op_ok(input logic [2:0] op);
`ifdef MDU_MADD_EN
    return 1'b1;
`else
    return op <= 3'd4;
`endif
  endfunction

  // Model: an op is pending until edge number m_end, when its result is applied.
  longint unsigned cyc = 0;
  longint unsigned m_end = 0;
  bit              pend = 0;
  logic [2:0]      m_op;
  logic [31:0]     m_a, m_b;
  logic [31:0]     m_hi = 0, m_lo = 0;

  task automatic apply_result();
    bit [63:0] hl, up, r;
    longint    sa, sb, sp, q, rm;
    hl = {m_hi, m_lo};
    sa = longint'(signed'(m_a));
    sb = longint'(signed'(m_b));
    sp = sa * sb;
    up = 64'(m_a) * 64'(m_b);
    r  = hl;
    case (m_op)
      3'd0: r = sp;
      3'd1: r = up;
      3'd4: r = hl - sp;
      3'd5: r = hl + sp;
      3'd6: r = hl + up;
      3'd7: r = hl - up;
      3'd2: if (m_b != 0) begin
        q  = sa / sb;
        rm = sa % sb;
        r  = {rm[31:0], q[31:0]};
      end
      3'd3: if (m_b != 0) begin
        r = {32'(64'(m_a) % 64'(m_b)), 32'(64'(m_a) / 64'(m_b))};
      end
      default: ;
    endcase
    {m_hi, m_lo} = r;
  endtask

  always @(posedge clk) begin
    bit was_pend, fin;
    longint unsigned e;
    e = cyc + 1;
    if (reset) begin
      m_hi = 0;
      m_lo = 0;
      pend = 0;
    end else begin
      was_pend = pend;
      fin      = pend && (e == m_end);
      if (fin) begin
        apply_result();
        pend = 0;
      end
      if (Start && op_ok(MDOp) && (!was_pend || fin)) begin
        m_op  = MDOp;
        m_a   = A;
        m_b   = B;
        m_end = e + ((MDOp == 3'd2 || MDOp == 3'd3) ? DIV_N : MULT_N);
        pend  = 1;
      end else if (!was_pend) begin
        if (HiLoWr == 2'b01) m_hi = WD;
        else if (HiLoWr == 2'b10) m_lo = WD;
      end
    end
    cyc = e;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, Busy}, {31'b0, pend});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
    end
  end

  task automatic hilo_write(input logic [1:0] sel, input logic [31:0] wd);
    HiLoWr = sel;
    WD     = wd;
    @(negedge clk);
    HiLoWr = 2'b00;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int n);
    MDOp  = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    n     = 0;
    while (Busy && n < 40) begin
      n++;
      if (inject && n == 1) begin
        Start  = 1'b1;
        MDOp   = 3'd0;
        A      = 32'd100;
        B      = 32'd100;
        HiLoWr = 2'b01;
        WD     = 32'd5;
      end else begin
        Start  = 1'b0;
        HiLoWr = 2'b00;
      end
      @(negedge clk);
    end
    Start  = 1'b0;
    HiLoWr = 2'b00;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'(-$urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  int n;

  initial begin
    reset  = 1'b1;
    Start  = 1'b0;
    MDOp   = 3'd0;
    A      = '0;
    B      = '0;
    HiLoWr = 2'b00;
    WD     = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    reset  = 1'b0;
    check("reset_busy", {31'b0, Busy}, 32'd0);
    check("reset_hi", HI, 32'h0);
    check("reset_lo", LO, 32'h0);

    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 0, n);
    check("mult_busy_cycles", n, MULT_N);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);
    check("mult_hi_model", m_hi, 32'hFFFF_FFFF);

    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0, n);
    check("multu_busy_cycles", n, MULT_N);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, n);
    check("div_busy_cycles", n, DIV_N);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    check("div_lo_model", m_lo, 32'hFFFF_FFFD);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, n);
    check("div_ovf_lo", LO, 32'h8000_0000);
    check("div_ovf_hi", HI, 32'h0);

    hilo_write(2'b01, 32'h11);
    hilo_write(2'b10, 32'h22);
    check("mthi", HI, 32'h11);
    check("mtlo", LO, 32'h22);
    run_op(3'd3, 32'd7, 32'd0, 0, n);
    check("divu0_busy_cycles", n, DIV_N);
    check("divu0_hi", HI, 32'h11);
    check("divu0_lo", LO, 32'h22);

    hilo_write(2'b01, 32'h0);
    hilo_write(2'b10, 32'd10);
    run_op(3'd4, 32'd3, 32'd4, 1, n);
    check("msub_busy_cycles", n, MULT_N);
    check("msub_lo", LO, 32'hFFFF_FFFE);
    check("msub_hi", HI, 32'hFFFF_FFFF);
    check("msub_hi_model", m_hi, 32'hFFFF_FFFF);

    MDOp  = 3'd0;
    A     = 32'h1234_5678;
    B     = 32'h9;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, Busy}, 32'd0);
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    repeat (8) @(negedge clk);
    check("abort_no_late_hi", HI, 32'h0);
    check("abort_no_late_lo", LO, 32'h0);

    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 399) == 0);
      Start  = ($urandom_range(0, 3) == 0);
      MDOp   = 3'($urandom_range(0, 7));
      A      = pick();
      B      = pick();
      HiLoWr = 2'($urandom_range(0, 3));
      WD     = $urandom;
      @(negedge clk);
    end
    reset  = 1'b0;
    Start  = 1'b0;
    HiLoWr = 2'b00;
    repeat (DIV_N + 2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
